mux_piso_tx: RTL and testbench
==============================

MUX_PISO_TX -- requirements
Module: mux_piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per frame (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 en  input  1  shift enable: 1 advances one bit; 0 holds all state, as a mux-feedback hold.
REQ-005 load_valid  input  1  parallel word offered on D.
REQ-006 D  input  WIDTH  parallel data word to transmit.
REQ-007 load_ready  output  1  block can accept a word; equals (state == IDLE).
REQ-008 ser_out  output  1  serial data, MSB first; 0 whenever ser_en = 0.
REQ-009 ser_en  output  1  frame active; equals (state == SHIFT).
REQ-010 done  output  1  one-cycle pulse after the last bit of a frame is shifted.

Function
REQ-011 States: IDLE and SHIFT only; internal WIDTH-bit shift register shreg; bit counter cnt of width clog2(WIDTH).
REQ-012 Load occurs on an edge with state = IDLE and load_valid = 1: shreg <= D, cnt <= 0, state <= SHIFT; en is ignored for load.
REQ-013 load_valid while state = SHIFT is ignored; D is not sampled and the frame in flight is unaffected.
REQ-014 ser_out = shreg[WIDTH-1] when in SHIFT; combinational from the register, no extra latency.
REQ-015 In SHIFT with en = 1: shreg <= {shreg[WIDTH-2:0], 1'b0}, cnt <= cnt + 1.
REQ-016 In SHIFT with en = 1 and cnt = WIDTH-1: state <= IDLE, cnt <= 0, done <= 1.
REQ-017 In SHIFT with en = 0: shreg, cnt and state hold; ser_out keeps presenting the same bit; done = 0.
REQ-018 A receiver samples ser_out on each edge where ser_en = 1 and en = 1; exactly WIDTH such edges per frame.
REQ-019 done is registered, high for exactly the first IDLE cycle after the frame, and 0 otherwise.
REQ-020 Load-to-first-bit latency: bit WIDTH-1 appears on ser_out in the cycle after the load edge.
REQ-021 No back-to-back frames: at least one IDLE cycle, in which done = 1 and load_ready = 1, separates frames. A load in that cycle starts the next frame.
REQ-022 cnt never exceeds WIDTH-1 and never wraps inside a frame.

Reset
REQ-023 On an edge with rst_n = 0: state <= IDLE, shreg <= 0, cnt <= 0, done <= 0; this overrides load and en.
REQ-024 Output values after reset: load_ready = 1, ser_en = 0, ser_out = 0, done = 0.
REQ-025 Reset during SHIFT aborts the frame without a done pulse; the partial frame is discarded.

Verification
REQ-026 Basic frame: WIDTH = 8, en = 1, load D = 8'hA5 -> ser_out over the next 8 cycles = 1,0,1,0,0,1,0,1 with ser_en = 1. The following cycle shows done = 1, ser_en = 0, load_ready = 1.
REQ-027 Stall: load 8'hC3, hold en = 0 for 2 cycles after the 3rd bit -> the 3rd bit (0) is held for 3 cycles. The sampled sequence is still 1,1,0,0,0,0,1,1 and done is delayed by 2 cycles.
REQ-028 Busy load: during the 8'hA5 frame, assert load_valid with D = 8'hFF -> the serial sequence is unchanged; 8'hFF is never transmitted unless re-offered in IDLE.
REQ-029 Back-to-back: keep load_valid = 1 with 8'h81 then 8'h7E -> exactly one gap cycle, with done = 1, between frames. The bits are 1,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,0.
REQ-030 Mid-frame reset: rst_n = 0 for 1 cycle after the 4th bit of 8'hF0 -> the next cycle shows ser_en = 0, ser_out = 0, done = 0, load_ready = 1. A fresh load of 8'h0F then transmits correctly.
REQ-031 Reset priority: rst_n = 0 together with load_valid = 1 -> no load occurs; the state remains IDLE.

Source files
------------

// File: rtl/mux_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : mux_piso_tx
// Description : Parallel-in / serial-out frame transmitter. A WIDTH-bit word
//               is accepted in IDLE and shifted out MSB first while en = 1.
//               en = 0 holds every register through its feedback mux.
//               A one-cycle done pulse marks the IDLE cycle after each frame.
// Ports       : clk        - clock, rising-edge active
//               rst_n      - synchronous active-low reset
//               en         - shift enable (ignored for the load itself)
//               load_valid - parallel word offered on D
//               D          - parallel data word
//               load_ready - high while IDLE (word can be accepted)
//               ser_out    - serial data, 0 outside a frame
//               ser_en     - high while a frame is being shifted
//               done       - one-cycle pulse after the last bit
// Revision    : 1.0 - initial release
// ============================================================================
module mux_piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] D,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;

    // State register; reset wins over load and enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic. Every register defaults to its own value, so en = 0
    // in SHIFT (and an idle cycle without load_valid) is a pure hold.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_shreg_nxt = D;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // load_valid is deliberately not looked at here: a busy
                // offer never disturbs the frame in flight.
                if (en) begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                    if (r_cnt == c_last_bit) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == IDLE);
    assign ser_en     = (r_state == SHIFT);
    // Gated so the line idles low; no extra register stage on the data path.
    assign ser_out    = ser_en & r_shreg[WIDTH-1];
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_piso_tx
// Description : Self-checking bench for mux_piso_tx. A queue-of-bits model
//               tracks the frame in flight; a receiver reassembles the bits
//               sampled on ser_en & en edges and compares each finished
//               frame against the word that was loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_piso_tx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             load_valid;
    logic [WIDTH-1:0] D;
    logic             load_ready;
    logic             ser_out;
    logic             ser_en;
    logic             done;

    mux_piso_tx #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .D          (D),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_en     (ser_en),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;

    // Reference model: bits still to send for the current frame (MSB first).
    bit               m_q[$];
    bit               m_done;
    logic [WIDTH-1:0] m_word;

    // Receiver side: bits seen on the serial line for the current frame.
    logic [WIDTH-1:0] rx_word;
    int               rx_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs mid-cycle, let the edge happen, advance the
    // model with the same inputs, then compare all outputs.
    task automatic step(input logic r, input logic e, input logic lv, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst_n      = r;
        en         = e;
        load_valid = lv;
        D          = d;
        if (r && e && (ser_en === 1'b1)) begin
            rx_word = {rx_word[WIDTH-2:0], ser_out};
            rx_cnt++;
        end
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (!r) begin
            m_q.delete();
            rx_cnt = 0;
        end else if (m_q.size() == 0) begin
            if (lv) begin
                m_word = d;
                for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(d[i]);
                rx_cnt = 0;
            end
        end else if (e) begin
            m_q.delete(0);
            if (m_q.size() == 0) begin
                m_done = 1'b1;
                frames++;
                check_val("rx_word", 32'(rx_word), 32'(m_word));
                check_val("rx_bits", 32'(rx_cnt), 32'(WIDTH));
            end
        end
        check_val("load_ready", 32'(load_ready), 32'(m_q.size() == 0));
        check_val("ser_en",     32'(ser_en),     32'(m_q.size() != 0));
        check_val("ser_out",    32'(ser_out),    (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check_val("done",       32'(done),       32'(m_done));
    endtask

    initial begin
        int f0;
        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        D          = '0;
        rx_word    = '0;
        rx_cnt     = 0;
        m_done     = 1'b0;
        m_word     = '0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check_val("rst_load_ready", 32'(load_ready), 32'd1);

        // Basic frame A5
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b0, '0);
        check_val("a5_done", 32'(done), 32'd1);
        step(1'b1, 1'b1, 1'b0, '0);

        // Stall on the third bit of C3
        step(1'b1, 1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        check_val("stall_bit3", 32'(ser_out), 32'd0);
        for (int i = 0; i < WIDTH - 2; i++) step(1'b1, 1'b1, 1'b0, '0);
        check_val("stall_done", 32'(done), 32'd1);
        step(1'b1, 1'b1, 1'b0, '0);

        // Busy load: FF offered throughout the A5 frame
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b1, 8'hFF);
        check_val("busy_word", 32'(rx_word), 32'hA5);
        step(1'b1, 1'b1, 1'b0, '0);

        // Back-to-back with load_valid held: one done gap, then 7E
        f0 = frames;
        step(1'b1, 1'b1, 1'b1, 8'h81);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b1, 8'h7E);
        check_val("b2b_gap_done", 32'(done), 32'd1);
        step(1'b1, 1'b1, 1'b1, 8'h7E);
        check_val("b2b_reload", 32'(ser_en), 32'd1);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b0, '0);
        check_val("b2b_frames", 32'(frames - f0), 32'd2);
        step(1'b1, 1'b1, 1'b0, '0);

        // Mid-frame reset after the 4th bit of F0, then a clean 0F frame
        step(1'b1, 1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check_val("mrst_ser_en", 32'(ser_en), 32'd0);
        check_val("mrst_done",   32'(done),   32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h0F);
        for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b0, '0);
        check_val("mrst_0f", 32'(rx_word), 32'h0F);

        // Reset has priority over load
        step(1'b0, 1'b1, 1'b1, 8'h55);
        check_val("rstpri_ready", 32'(load_ready), 32'd1);
        step(1'b1, 1'b0, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 150) != 0, ($urandom % 4) != 0,
                 ($urandom % 3) == 0, WIDTH'($urandom));
        end
        check_val("rand_frames_seen", 32'(frames > 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
